// File: rtl/print_tx_if.sv
// Bundles the per-core PRINT inputs and the serial/status outputs of print_tx.
// The cores (or a testbench) drive through the master modport.
// print_tx itself connects through the slave modport.
interface print_tx_if #(
    parameter int NCORES = 4
);
    logic [NCORES*16-1:0] print_bus;
    logic [NCORES-1:0]    print_valid;
    logic [NCORES-1:0]    print_busy;
    logic [NCORES-1:0]    overrun;
    logic                 uart_tx;
    logic                 tx_active;

    modport master (
        output print_bus, print_valid,
        input  print_busy, overrun, uart_tx, tx_active
    );

    modport slave (
        input  print_bus, print_valid,
        output print_busy, overrun, uart_tx, tx_active
    );
endinterface

// File: rtl/print_tx.sv
// print_tx: gathers PRINT values from NCORES cores into per-core slots.
// A round-robin arbiter drains the slots into a shared FIFO, one per cycle.
// The low byte of each FIFO entry is sent as an 8N1 UART frame.
module print_tx #(
    parameter int NCORES       = 4,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic      clk,
    input  logic      rst,
    print_tx_if.slave io
);
    localparam int IDX_W  = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Per-core slots and arbitration
    logic [15:0]       slot_data [NCORES];
    logic [NCORES-1:0] slot_full;
    logic [NCORES-1:0] overrun_q;
    logic [IDX_W-1:0]  rr_ptr;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W:0]    cand;

    // Shared FIFO
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // Transmitter
    tx_state_t         state;
    tx_state_t         state_d;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_d;
    logic [7:0]        shift;
    logic [7:0]        shift_d;
    logic              uart_q;
    logic              uart_d;
    logic              baud_done;

    // Pick the first full slot at or after rr_ptr, wrapping, while the FIFO has room.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NCORES; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NCORES)) begin
                cand = cand - (IDX_W+1)'(NCORES);
            end
            if (!grant_valid && !fifo_full && slot_full[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Track slot occupancy, sticky overruns and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= '0;
            overrun_q <= '0;
            rr_ptr    <= '0;
        end else begin
            // NOTE: non-blocking, so every test of slot_full here sees the value from before this edge;
            // a slot granted on this edge therefore still counts as full for an incoming PRINT.
            for (int i = 0; i < NCORES; i++) begin
                if (io.print_valid[i]) begin
                    if (slot_full[i]) begin
                        overrun_q[i] <= 1'b1;
                    end else begin
                        slot_full[i] <= 1'b1;
                    end
                end
            end
            if (grant_valid) begin
                slot_full[grant_idx] <= 1'b0;
                rr_ptr <= (grant_idx == IDX_W'(NCORES - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Capture the PRINT value into an empty slot.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; slot_full (and the FIFO pointers below) say what is valid.
        for (int i = 0; i < NCORES; i++) begin
            if (io.print_valid[i] && !slot_full[i]) begin
                slot_data[i] <= io.print_bus[i*16 +: 16];
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign push       = grant_valid;
    assign pop        = (state == IDLE) && !fifo_empty;

    // Advance the FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Write the granted slot's value into the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[ADDR_W-1:0]] <= slot_data[grant_idx];
        end
    end

    assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    // Frame sequencing: next state, baud/bit counters, shifter and next line level.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        uart_d  = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                    shift_d = fifo_mem[rd_ptr[ADDR_W-1:0]][7:0];
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift[7:1]};
                        bit_d   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   uart_d = 1'b0;
            DATA:    uart_d = shift_d[0];
            default: uart_d = 1'b1;
        endcase
    end

    // Transmitter registers; the line level is registered so uart_tx is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_q   <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            uart_q   <= uart_d;
        end
    end

    assign io.print_busy = slot_full;
    assign io.overrun    = overrun_q;
    assign io.uart_tx    = uart_q;
    assign io.tx_active  = (state != IDLE);

endmodule
